multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control_if.sv | 40 ++++
 rtl/multi_cycle_control.sv | 203 ++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_control_if.sv
// multi_cycle_control_if -- bus between the multi-cycle controller and its datapath.
//   master : controller side (drives the strobes, samples instr/ready/zero)
//   slave  : datapath side
//   instr[15:0], imem_ready, dmem_ready, zero  datapath -> controller
//   ALUOp[1:0], Function[3:0]                  ALU control decoder inputs
//   ir_write, pc_write, mem_read, mem_write,
//   reg_write, mem_to_reg, reg_dst, alu_src_imm datapath strobes and selects
//   illegal, timeout                           one-cycle error pulses
//   state[2:0]                                 current FSM state (debug)
interface multi_cycle_control_if;
    logic [15:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        zero;
    logic [1:0]  ALUOp;
    logic [3:0]  Function;
    logic        ir_write;
    logic        pc_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        alu_src_imm;
    logic        illegal;
    logic        timeout;
    logic [2:0]  state;

    modport master (
        input  instr, imem_ready, dmem_ready, zero,
        output ALUOp, Function, ir_write, pc_write, mem_read, mem_write,
               reg_write, mem_to_reg, reg_dst, alu_src_imm, illegal, timeout, state
    );

    modport slave (
        output instr, imem_ready, dmem_ready, zero,
        input  ALUOp, Function, ir_write, pc_write, mem_read, mem_write,
               reg_write, mem_to_reg, reg_dst, alu_src_imm, illegal, timeout, state
    );
endinterface

// File: rtl/multi_cycle_control.sv
// multi_cycle_control -- control FSM for a 16-bit multi-cycle CPU.
//   Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction, with a
//   bounded wait on imem_ready / dmem_ready that aborts to FETCH after TIMEOUT
//   cycles.
// Parameters:
//   TIMEOUT  maximum wait cycles for a ready input before abort (1..255)
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high
//   bus      multi_cycle_control_if.master (instr/ready/zero in, strobes out)
// Build option:
//   MCC_HALT_EN  when defined, opcode 1111 enters HALT (held until reset);
//                otherwise 1111 is decoded as illegal.
module multi_cycle_control #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    multi_cycle_control_if.master  bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_R    = 4'b0000,
        OP_LW   = 4'b0001,
        OP_SW   = 4'b0010,
        OP_BEQ  = 4'b0011,
        OP_ADDI = 4'b0100,
        OP_ORI  = 4'b0101,
        OP_JMP  = 4'b0110,
        OP_HALT = 4'b1111
    } op_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      cur, nxt;
    logic [3:0]  opcode;
    logic [3:0]  fn_q;
    logic [7:0]  wait_cnt;
    logic        wait_expired;

    logic [1:0]  alu_op;
    logic        ir_write, pc_write, mem_read, mem_write;
    logic        reg_write, mem_to_reg, reg_dst, alu_src_imm;
    logic        illegal, timeout;

    // Only opcode and function fields are decoded here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[11:4];

    // Counter value at which one more not-ready cycle reaches TIMEOUT.
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= FETCH;
            opcode   <= '0;
            fn_q     <= '0;
            wait_cnt <= '0;
        end else begin
            cur <= nxt;
            if (ir_write) begin
                opcode <= bus.instr[15:12];
                fn_q   <= bus.instr[3:0];
            end
            // Any state change (including the FETCH->FETCH abort) restarts the wait.
            if (nxt != cur || timeout) begin
                wait_cnt <= '0;
            end else if ((cur == FETCH && !bus.imem_ready) ||
                         (cur == MEM   && !bus.dmem_ready)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // ir_write/pc_write in FETCH and the timeout pulse are qualified by the
    // ready input of the same cycle so that an immediately-ready fetch costs a
    // single cycle and ready on the last allowed cycle still completes.
    always_comb begin
        nxt         = cur;
        alu_op      = 2'b00;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        alu_src_imm = 1'b0;
        illegal     = 1'b0;
        timeout     = 1'b0;

        case (cur)
            FETCH: begin
                mem_read = 1'b1;
                if (bus.imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end else if (wait_expired) begin
                    timeout = 1'b1;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_JMP: nxt = EXEC;
`ifdef MCC_HALT_EN
                    OP_HALT: nxt = HALT;
`endif
                    default: begin
                        illegal = 1'b1;
                        nxt     = FETCH;
                    end
                endcase
            end
            EXEC: begin
                case (opcode)
                    OP_LW, OP_SW: begin
                        alu_op      = 2'b11;
                        alu_src_imm = 1'b1;
                        nxt         = MEM;
                    end
                    OP_ADDI: begin
                        alu_op      = 2'b11;
                        alu_src_imm = 1'b1;
                        nxt         = WB;
                    end
                    OP_ORI: begin
                        alu_op      = 2'b10;
                        alu_src_imm = 1'b1;
                        nxt         = WB;
                    end
                    OP_BEQ: begin
                        alu_op   = 2'b01;
                        pc_write = bus.zero;
                        nxt      = FETCH;
                    end
                    OP_JMP: begin
                        pc_write = 1'b1;
                        nxt      = FETCH;
                    end
                    default: nxt = WB;
                endcase
            end
            MEM: begin
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode == OP_SW);
                if (bus.dmem_ready) begin
                    nxt = (opcode == OP_LW) ? WB : FETCH;
                end else if (wait_expired) begin
                    timeout = 1'b1;
                    nxt     = FETCH;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_R);
                mem_to_reg = (opcode == OP_LW);
                nxt        = FETCH;
            end
            HALT: nxt = HALT;
            default: nxt = FETCH;
        endcase

        // Reset blanks every strobe immediately, independent of the clock.
        if (reset) begin
            alu_op      = 2'b00;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            mem_to_reg  = 1'b0;
            reg_dst     = 1'b0;
            alu_src_imm = 1'b0;
            illegal     = 1'b0;
            timeout     = 1'b0;
        end
    end

    assign bus.ALUOp       = alu_op;
    assign bus.Function    = fn_q;
    assign bus.ir_write    = ir_write;
    assign bus.pc_write    = pc_write;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.reg_write   = reg_write;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.reg_dst     = reg_dst;
    assign bus.alu_src_imm = alu_src_imm;
    assign bus.illegal     = illegal;
    assign bus.timeout     = timeout;
    assign bus.state       = cur;

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic        im;
        logic        dm;
        logic        z;
        logic [2:0]  st;
        logic [9:0]  strb;  // ir pc rd wr rw m2r rdst imm ill to
        logic [1:0]  alu;
        logic [3:0]  fn;
    } vec_t;

    localparam logic [9:0] S_NONE  = 10'b0000000000;
    localparam logic [9:0] S_FETCH = 10'b1110000000;
    localparam logic [9:0] S_FWAIT = 10'b0010000000;
    localparam logic [9:0] S_FTO   = 10'b0010000001;
    localparam logic [9:0] S_IMM   = 10'b0000000100;
    localparam logic [9:0] S_PC    = 10'b0100000000;
    localparam logic [9:0] S_RD    = 10'b0010000000;
    localparam logic [9:0] S_WR    = 10'b0001000000;
    localparam logic [9:0] S_WRTO  = 10'b0001000001;
    localparam logic [9:0] S_WB    = 10'b0000100000;
    localparam logic [9:0] S_WBR   = 10'b0000101000;
    localparam logic [9:0] S_WBM   = 10'b0000110000;
    localparam logic [9:0] S_ILL   = 10'b0000000010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    multi_cycle_control_if bus();

    multi_cycle_control #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic [15:0] i, logic im, logic dm, logic z,
                                logic [2:0] st, logic [9:0] s, logic [1:0] a, logic [3:0] f);
        vec_t v;
        v.name = n; v.instr = i; v.im = im; v.dm = dm; v.z = z;
        v.st = st; v.strb = s; v.alu = a; v.fn = f;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.instr      = v.instr;
        bus.imem_ready = v.im;
        bus.dmem_ready = v.dm;
        bus.zero       = v.z;
        exp_q.push_back(v);
    endtask

    task automatic check_out();
        vec_t e;
        logic [9:0] s;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty");
            return;
        end
        e = exp_q.pop_front();
        s = {bus.ir_write, bus.pc_write, bus.mem_read, bus.mem_write, bus.reg_write,
             bus.mem_to_reg, bus.reg_dst, bus.alu_src_imm, bus.illegal, bus.timeout};
        checks++;
        if (bus.state !== e.st || s !== e.strb || bus.ALUOp !== e.alu || bus.Function !== e.fn) begin
            errors++;
            $display("FAIL %s got st=%0d strb=%b alu=%b fn=%h exp st=%0d strb=%b alu=%b fn=%h",
                     e.name, bus.state, s, bus.ALUOp, bus.Function, e.st, e.strb, e.alu, e.fn);
        end
    endtask

    // Inputs applied on the falling edge, outputs compared 1 ns later.
    task automatic apply(input vec_t v);
        drive(v);
        #1;
        check_out();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // R-type, ADDI, ORI
        tbl.push_back(mk("r_fetch",    16'h0012, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h0));
        tbl.push_back(mk("r_dec",      16'h0012, 1, 0, 0, 3'd1, S_NONE,  2'b00, 4'h2));
        tbl.push_back(mk("r_exec",     16'h0012, 1, 0, 0, 3'd2, S_NONE,  2'b00, 4'h2));
        tbl.push_back(mk("r_wb",       16'h0012, 1, 0, 0, 3'd4, S_WBR,   2'b00, 4'h2));
        tbl.push_back(mk("addi_fetch", 16'h4005, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h2));
        tbl.push_back(mk("addi_dec",   16'h4005, 1, 0, 0, 3'd1, S_NONE,  2'b00, 4'h5));
        tbl.push_back(mk("addi_exec",  16'h4005, 1, 0, 0, 3'd2, S_IMM,   2'b11, 4'h5));
        tbl.push_back(mk("addi_wb",    16'h4005, 1, 0, 0, 3'd4, S_WB,    2'b00, 4'h5));
        tbl.push_back(mk("ori_fetch",  16'h5003, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h5));
        tbl.push_back(mk("ori_dec",    16'h5003, 1, 0, 0, 3'd1, S_NONE,  2'b00, 4'h3));
        tbl.push_back(mk("ori_exec",   16'h5003, 1, 0, 0, 3'd2, S_IMM,   2'b10, 4'h3));
        tbl.push_back(mk("ori_wb",     16'h5003, 1, 0, 0, 3'd4, S_WB,    2'b00, 4'h3));
        // LW with dmem_ready low 3 cycles, high on the last allowed cycle
        tbl.push_back(mk("lw_fetch",   16'h1000, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h3));
        tbl.push_back(mk("lw_dec",     16'h1000, 1, 0, 0, 3'd1, S_NONE,  2'b00, 4'h0));
        tbl.push_back(mk("lw_exec",    16'h1000, 1, 0, 0, 3'd2, S_IMM,   2'b11, 4'h0));
        tbl.push_back(mk("lw_mem0",    16'h1000, 1, 0, 0, 3'd3, S_RD,    2'b00, 4'h0));
        tbl.push_back(mk("lw_mem1",    16'h1000, 1, 0, 0, 3'd3, S_RD,    2'b00, 4'h0));
        tbl.push_back(mk("lw_mem2",    16'h1000, 1, 0, 0, 3'd3, S_RD,    2'b00, 4'h0));
        tbl.push_back(mk("lw_mem3",    16'h1000, 1, 1, 0, 3'd3, S_RD,    2'b00, 4'h0));
        tbl.push_back(mk("lw_wb",      16'h1000, 1, 0, 0, 3'd4, S_WBM,   2'b00, 4'h0));
        // SW, BEQ taken / not taken, JMP, illegal
        tbl.push_back(mk("sw_fetch",   16'h2000, 1, 1, 0, 3'd0, S_FETCH, 2'b00, 4'h0));
        tbl.push_back(mk("sw_dec",     16'h2000, 1, 1, 0, 3'd1, S_NONE,  2'b00, 4'h0));
        tbl.push_back(mk("sw_exec",    16'h2000, 1, 1, 0, 3'd2, S_IMM,   2'b11, 4'h0));
        tbl.push_back(mk("sw_mem",     16'h2000, 1, 1, 0, 3'd3, S_WR,    2'b00, 4'h0));
        tbl.push_back(mk("beq1_fetch", 16'h3000, 1, 0, 1, 3'd0, S_FETCH, 2'b00, 4'h0));
        tbl.push_back(mk("beq1_dec",   16'h3000, 1, 0, 1, 3'd1, S_NONE,  2'b00, 4'h0));
        tbl.push_back(mk("beq1_exec",  16'h3000, 1, 0, 1, 3'd2, S_PC,    2'b01, 4'h0));
        tbl.push_back(mk("beq0_fetch", 16'h3000, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h0));
        tbl.push_back(mk("beq0_dec",   16'h3000, 1, 0, 0, 3'd1, S_NONE,  2'b00, 4'h0));
        tbl.push_back(mk("beq0_exec",  16'h3000, 1, 0, 0, 3'd2, S_NONE,  2'b01, 4'h0));
        tbl.push_back(mk("jmp_fetch",  16'h6009, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h0));
        tbl.push_back(mk("jmp_dec",    16'h6009, 1, 0, 0, 3'd1, S_NONE,  2'b00, 4'h9));
        tbl.push_back(mk("jmp_exec",   16'h6009, 1, 0, 0, 3'd2, S_PC,    2'b00, 4'h9));
        tbl.push_back(mk("ill_fetch",  16'h7000, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h9));
        tbl.push_back(mk("ill_dec",    16'h7000, 1, 0, 0, 3'd1, S_ILL,   2'b00, 4'h0));
        // FETCH timeout, then FETCH with ready on the last allowed cycle
        tbl.push_back(mk("ifto_w0",    16'h0000, 0, 0, 0, 3'd0, S_FWAIT, 2'b00, 4'h0));
        tbl.push_back(mk("ifto_w1",    16'h0000, 0, 0, 0, 3'd0, S_FWAIT, 2'b00, 4'h0));
        tbl.push_back(mk("ifto_w2",    16'h0000, 0, 0, 0, 3'd0, S_FWAIT, 2'b00, 4'h0));
        tbl.push_back(mk("ifto_hit",   16'h0000, 0, 0, 0, 3'd0, S_FTO,   2'b00, 4'h0));
        tbl.push_back(mk("ifw_w0",     16'h0004, 0, 0, 0, 3'd0, S_FWAIT, 2'b00, 4'h0));
        tbl.push_back(mk("ifw_w1",     16'h0004, 0, 0, 0, 3'd0, S_FWAIT, 2'b00, 4'h0));
        tbl.push_back(mk("ifw_w2",     16'h0004, 0, 0, 0, 3'd0, S_FWAIT, 2'b00, 4'h0));
        tbl.push_back(mk("ifw_ready",  16'h0004, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h0));
        tbl.push_back(mk("ifw_dec",    16'h0004, 1, 0, 0, 3'd1, S_NONE,  2'b00, 4'h4));
        tbl.push_back(mk("ifw_exec",   16'h0004, 1, 0, 0, 3'd2, S_NONE,  2'b00, 4'h4));
        tbl.push_back(mk("ifw_wb",     16'h0004, 1, 0, 0, 3'd4, S_WBR,   2'b00, 4'h4));
        // SW with dmem_ready held low: 4 cycles of mem_write, timeout on the 4th
        tbl.push_back(mk("swto_fetch", 16'h2000, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h4));
        tbl.push_back(mk("swto_dec",   16'h2000, 1, 0, 0, 3'd1, S_NONE,  2'b00, 4'h0));
        tbl.push_back(mk("swto_exec",  16'h2000, 1, 0, 0, 3'd2, S_IMM,   2'b11, 4'h0));
        tbl.push_back(mk("swto_mem0",  16'h2000, 1, 0, 0, 3'd3, S_WR,    2'b00, 4'h0));
        tbl.push_back(mk("swto_mem1",  16'h2000, 1, 0, 0, 3'd3, S_WR,    2'b00, 4'h0));
        tbl.push_back(mk("swto_mem2",  16'h2000, 1, 0, 0, 3'd3, S_WR,    2'b00, 4'h0));
        tbl.push_back(mk("swto_hit",   16'h2000, 1, 0, 0, 3'd3, S_WRTO,  2'b00, 4'h0));
        tbl.push_back(mk("swto_after", 16'h0012, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h0));
        tbl.push_back(mk("post_dec",   16'h0012, 1, 0, 0, 3'd1, S_NONE,  2'b00, 4'h2));
        tbl.push_back(mk("post_exec",  16'h0012, 1, 0, 0, 3'd2, S_NONE,  2'b00, 4'h2));
        tbl.push_back(mk("post_wb",    16'h0012, 1, 0, 0, 3'd4, S_WBR,   2'b00, 4'h2));

        // Reset state, with imem_ready high to show strobes are held off.
        drive(mk("reset_state", 16'h0012, 1, 1, 1, 3'd0, S_NONE, 2'b00, 4'h0));
        #1;
        check_out();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Opcode 1111
        apply(mk("f_fetch", 16'hF000, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h2));
`ifdef MCC_HALT_EN
        apply(mk("f_dec",   16'hF000, 1, 1, 1, 3'd1, S_NONE, 2'b00, 4'h0));
        for (int i = 0; i < 3; i++) begin
            apply(mk("f_halt", 16'hF000, 1, 1, 1, 3'd5, S_NONE, 2'b00, 4'h0));
        end
`else
        apply(mk("f_dec",   16'hF000, 1, 0, 0, 3'd1, S_ILL,   2'b00, 4'h0));
        apply(mk("f_fetch2", 16'hF000, 0, 0, 0, 3'd0, S_FWAIT, 2'b00, 4'h0));
`endif

        // Reset mid-instruction: leaves HALT or pending FETCH alike.
        reset = 1'b1;
        drive(mk("rst_again", 16'h2007, 1, 1, 0, 3'd0, S_NONE, 2'b00, 4'h0));
        #1;
        check_out();
        @(negedge clk);
        reset = 1'b0;
        apply(mk("rs_fetch", 16'h2007, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h0));
        apply(mk("rs_dec",   16'h2007, 1, 0, 0, 3'd1, S_NONE,  2'b00, 4'h7));
        apply(mk("rs_exec",  16'h2007, 1, 0, 0, 3'd2, S_IMM,   2'b11, 4'h7));
        drive(mk("rs_mem",   16'h2007, 1, 0, 0, 3'd3, S_WR,    2'b00, 4'h7));
        #1;
        check_out();
        #2;
        reset = 1'b1;
        drive(mk("rst_mid_mem", 16'h2007, 1, 0, 0, 3'd0, S_NONE, 2'b00, 4'h0));
        #1;
        check_out();
        @(negedge clk);
        reset = 1'b0;
        apply(mk("rs_post_fetch", 16'h0012, 0, 0, 0, 3'd0, S_FWAIT, 2'b00, 4'h0));
        apply(mk("rs_post_ready", 16'h0012, 1, 0, 0, 3'd0, S_FETCH, 2'b00, 4'h0));

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
